// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with one word of look-ahead buffering so that
// consecutive words stream out with no idle cycle between them.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pb_q, pb_d;
    logic             pf_q, pf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] sr_shift_s;

    // State register: async active-low reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= {WIDTH{1'b0}};
            pb_q    <= {WIDTH{1'b0}};
            pf_q    <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            pb_q    <= pb_d;
            pf_q    <= pf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: shift, buffer a look-ahead word, reload on the last bit.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        pb_d       = pb_q;
        pf_d       = pf_q;
        cnt_d      = cnt_q;
        accept_s   = in_valid & ~pf_q;
        last_s     = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        if (MSB_FIRST) begin
            sr_shift_s = {sr_q[WIDTH-2:0], 1'b0};
        end else begin
            sr_shift_s = {1'b0, sr_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sr_d    = in_data;
                    cnt_d   = CNT_ZERO;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!last_s) begin
                    sr_d  = sr_shift_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (accept_s) begin
                        pb_d = in_data;
                        pf_d = 1'b1;
                    end else begin
                        pf_d = pf_q;
                    end
                end else if (pf_q) begin
                    // Buffered word follows immediately; PB refills only on a fresh accept.
                    sr_d  = pb_q;
                    cnt_d = CNT_ZERO;
                    if (accept_s) begin
                        pb_d = in_data;
                        pf_d = 1'b1;
                    end else begin
                        pf_d = 1'b0;
                    end
                end else if (accept_s) begin
                    sr_d  = in_data;
                    cnt_d = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pf_d    = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign ser_valid = busy;
    assign ser_out   = busy & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
    assign word_done = busy & (cnt_q == CNT_LAST);
    assign in_ready  = ~pf_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three instances (8-bit MSB-first,
// 8-bit LSB-first, 4-bit MSB-first) checked against hand-computed bit streams.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_data, b_data;
    logic [3:0] c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, a_out, a_sv, a_busy, a_done;
    logic       b_ready, b_out, b_sv, b_busy, b_done;
    logic       c_ready, c_out, c_sv, c_busy, c_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit a_b[$], a_d[$], a_r[$];
    int a_c[$];
    bit b_b[$], b_d[$];
    int b_c[$];
    bit c_b[$], c_d[$];
    int c_c[$];

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .ser_out(a_out), .ser_valid(a_sv), .busy(a_busy),
        .word_done(a_done)
    );
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .ser_out(b_out), .ser_valid(b_sv), .busy(b_busy),
        .word_done(b_done)
    );
    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .reset(rst_n), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .ser_out(c_out), .ser_valid(c_sv), .busy(c_busy),
        .word_done(c_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid serial bit mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (a_sv) begin
            a_b.push_back(a_out); a_d.push_back(a_done);
            a_r.push_back(a_ready); a_c.push_back(cyc);
        end
        if (b_sv) begin
            b_b.push_back(b_out); b_d.push_back(b_done); b_c.push_back(cyc);
        end
        if (c_sv) begin
            c_b.push_back(c_out); c_d.push_back(c_done); c_c.push_back(cyc);
        end
    end

    // Present a word and hold it until an edge where in_ready was high; returns #1 after that edge.
    task automatic send(input int sel, input logic [7:0] w);
        logic rdy;
        int   guard;
        guard = 0;
        case (sel)
            0:       begin a_data = w;      a_valid = 1'b1; end
            1:       begin b_data = w;      b_valid = 1'b1; end
            default: begin c_data = w[3:0]; c_valid = 1'b1; end
        endcase
        forever begin
            rdy = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 40) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout sel=%0d word=%h: in_ready stayed 0, required 1 within 40 cycles", sel, w);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = 8'h00; b_data = 8'h00; c_data = 4'h0;
        #23;
        n_checks++;
        if ({a_out, a_sv, a_busy, a_done, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_a got %b required 00001", {a_out, a_sv, a_busy, a_done, a_ready});
        end
        n_checks++;
        if ({b_out, b_sv, b_busy, b_done, b_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_b got %b required 00001", {b_out, b_sv, b_busy, b_done, b_ready});
        end
        n_checks++;
        if ({c_out, c_sv, c_busy, c_done, c_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_c got %b required 00001", {c_out, c_sv, c_busy, c_done, c_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({a_out, a_sv, a_busy, a_done, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL post_reset_a got %b required 00001", {a_out, a_sv, a_busy, a_done, a_ready});
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        int base, t0, n;
        w = 8'hB6;
        base = a_b.size();
        send(0, w);
        t0 = cyc;
        a_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n = a_b.size() - base;
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL single_count got %0d bits required 8", n); end
        for (int i = 0; i < n && i < 8; i++) begin
            n_checks++;
            if (a_b[base+i] !== w[7-i]) begin n_fail++; $display("FAIL single_bit%0d got %b required %b", i, a_b[base+i], w[7-i]); end
            n_checks++;
            if (a_d[base+i] !== (i == 7)) begin n_fail++; $display("FAIL single_done%0d got %b required %b", i, a_d[base+i], (i == 7)); end
            n_checks++;
            if (a_r[base+i] !== 1'b1) begin n_fail++; $display("FAIL single_ready%0d got %b required 1", i, a_r[base+i]); end
            n_checks++;
            if (a_c[base+i] !== t0 + i) begin n_fail++; $display("FAIL single_cycle%0d got %0d required %0d", i, a_c[base+i], t0 + i); end
        end
        n_checks++;
        if ({a_out, a_sv, a_busy, a_done, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL single_idle got %b required 00001", {a_out, a_sv, a_busy, a_done, a_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        int base, t0, n;
        exp = 16'hB6A5;
        base = a_b.size();
        send(0, exp[15:8]);
        t0 = cyc;
        send(0, exp[7:0]);
        a_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n = a_b.size() - base;
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL b2b_count got %0d bits required 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            n_checks++;
            if (a_b[base+i] !== exp[15-i]) begin n_fail++; $display("FAIL b2b_bit%0d got %b required %b", i, a_b[base+i], exp[15-i]); end
            n_checks++;
            if (a_d[base+i] !== (i == 7 || i == 15)) begin n_fail++; $display("FAIL b2b_done%0d got %b required %b", i, a_d[base+i], (i == 7 || i == 15)); end
            n_checks++;
            if (a_c[base+i] !== t0 + i) begin n_fail++; $display("FAIL b2b_cycle%0d got %0d required %0d", i, a_c[base+i], t0 + i); end
        end
    endtask

    task automatic test_three_words();
        logic [23:0] exp;
        int base, t0, n;
        exp = 24'hC35A0F;
        base = a_b.size();
        send(0, exp[23:16]);
        t0 = cyc;
        send(0, exp[15:8]);
        n_checks++;
        if (a_ready !== 1'b0) begin n_fail++; $display("FAIL three_ready_drop got %b required 0", a_ready); end
        send(0, exp[7:0]);
        a_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n = a_b.size() - base;
        n_checks++;
        if (n != 24) begin n_fail++; $display("FAIL three_count got %0d bits required 24", n); end
        for (int i = 0; i < n && i < 24; i++) begin
            n_checks++;
            if (a_b[base+i] !== exp[23-i]) begin n_fail++; $display("FAIL three_bit%0d got %b required %b", i, a_b[base+i], exp[23-i]); end
            n_checks++;
            if (a_d[base+i] !== (i % 8 == 7)) begin n_fail++; $display("FAIL three_done%0d got %b required %b", i, a_d[base+i], (i % 8 == 7)); end
            n_checks++;
            if (a_c[base+i] !== t0 + i) begin n_fail++; $display("FAIL three_cycle%0d got %0d required %0d", i, a_c[base+i], t0 + i); end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [7:0] exp_seq;
        int base, t0, n;
        w = 8'hB6;
        exp_seq = 8'b0110_1101;
        base = b_b.size();
        send(1, w);
        t0 = cyc;
        b_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n = b_b.size() - base;
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL lsb_count got %0d bits required 8", n); end
        for (int i = 0; i < n && i < 8; i++) begin
            n_checks++;
            if (b_b[base+i] !== exp_seq[7-i]) begin n_fail++; $display("FAIL lsb_bit%0d got %b required %b", i, b_b[base+i], exp_seq[7-i]); end
            n_checks++;
            if (b_d[base+i] !== (i == 7)) begin n_fail++; $display("FAIL lsb_done%0d got %b required %b", i, b_d[base+i], (i == 7)); end
            n_checks++;
            if (b_c[base+i] !== t0 + i) begin n_fail++; $display("FAIL lsb_cycle%0d got %0d required %0d", i, b_c[base+i], t0 + i); end
        end
    endtask

    task automatic test_width4();
        logic [7:0] exp;
        int base, t0, n;
        exp = 8'b1011_1011;
        base = c_b.size();
        send(2, 8'h0B);
        t0 = cyc;
        send(2, 8'h0B);
        c_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n = c_b.size() - base;
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL w4_count got %0d bits required 8", n); end
        for (int i = 0; i < n && i < 8; i++) begin
            n_checks++;
            if (c_b[base+i] !== exp[7-i]) begin n_fail++; $display("FAIL w4_bit%0d got %b required %b", i, c_b[base+i], exp[7-i]); end
            n_checks++;
            if (c_d[base+i] !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL w4_done%0d got %b required %b", i, c_d[base+i], (i == 3 || i == 7)); end
            n_checks++;
            if (c_c[base+i] !== t0 + i) begin n_fail++; $display("FAIL w4_cycle%0d got %0d required %0d", i, c_c[base+i], t0 + i); end
        end
    endtask

    task automatic test_reset_mid_word();
        int base;
        send(0, 8'hFF);
        send(0, 8'h3C);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({a_out, a_busy, a_ready} !== 3'b110) begin
            n_fail++; $display("FAIL midrst_pre got out/busy/ready %b required 110", {a_out, a_busy, a_ready});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_out, a_sv, a_busy, a_done, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL midrst_async got %b required 00001", {a_out, a_sv, a_busy, a_done, a_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = a_b.size();
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (a_b.size() != base) begin n_fail++; $display("FAIL midrst_leftover got %0d bits required 0", a_b.size() - base); end
        n_checks++;
        if ({a_out, a_sv, a_busy, a_done, a_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL midrst_after got %b required 00001", {a_out, a_sv, a_busy, a_done, a_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_three_words();
        test_lsb_first();
        test_width4();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
